// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch engine.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID
  } fetch_state_t;

  localparam int DEF_ADDR_W       = 24;
  localparam int DEF_DATA_W       = 8;
  localparam int DEF_INSTR_BYTES  = 4;
  localparam int DEF_READ_LATENCY = 3;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

  localparam int LAT_W = $clog2(DEF_READ_LATENCY + 1);
  localparam int IDX_W = $clog2(DEF_INSTR_BYTES + 1);

  // Counter width able to hold 0..n; never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_assembler.sv
// Collects flash lanes into a staging word and commits the full
// little-endian instruction only when the last lane arrives.
module fetch_assembler
  import fetch_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int IDX_W       = cnt_w(INSTR_BYTES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_i,
  input  logic                          wr_en_i,
  input  logic                          last_i,
  input  logic [IDX_W-1:0]              idx_i,
  input  logic [DATA_W-1:0]             data_i,
  output logic [INSTR_BYTES*DATA_W-1:0] instr_o
);

  localparam int W = INSTR_BYTES * DATA_W;

  logic [W-1:0] stage_q, stage_d;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] lane_w;

  always_comb begin
    lane_w = stage_q;
    for (int k = 0; k < INSTR_BYTES; k++) begin
      if (idx_i == IDX_W'(k)) begin
        lane_w[k*DATA_W +: DATA_W] = data_i;
      end
    end
    stage_d = stage_q;
    instr_d = instr_q;
    if (clear_i) begin
      stage_d = '0;
    end else if (wr_en_i) begin
      if (last_i) begin
        instr_d = lane_w;
        stage_d = '0;
      end else begin
        stage_d = lane_w;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      instr_q <= '0;
    end else begin
      stage_q <= stage_d;
      instr_q <= instr_d;
    end
  end

  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch engine: owns the PC, sequences multi-cycle byte
// reads from flash and hands out whole words on valid/ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          redirect,
  input  logic [ADDR_W-1:0]             redirect_addr,
  output logic                          flash_re,
  output logic [ADDR_W-1:0]             flash_addr,
  input  logic [DATA_W-1:0]             flash_rdata,
  output logic [INSTR_BYTES*DATA_W-1:0] instr,
  output logic [ADDR_W-1:0]             instr_pc,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic                          busy
);

  localparam int LW = cnt_w(READ_LATENCY);
  localparam int IW = cnt_w(INSTR_BYTES);

  fetch_state_t    state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            lat_done;
  logic            last;
  logic            cap;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ipc_d    = ipc_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    lat_done = (lat_q == LW'(READ_LATENCY - 1));
    last     = (idx_q == IW'(INSTR_BYTES - 1));
    cap      = (state_q == FETCH) && lat_done && !redirect;
    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
          idx_d   = '0;
          lat_d   = '0;
          ipc_d   = pc_q;
        end
      end
      FETCH: begin
        if (lat_done) begin
          lat_d = '0;
          if (last) begin
            state_d = VALID;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      VALID: begin
        if (instr_ready) begin
          pc_d  = pc_q + ADDR_W'(INSTR_BYTES);
          idx_d = '0;
          lat_d = '0;
          if (run) begin
            state_d = FETCH;
            ipc_d   = pc_d;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Redirect overrides everything, including a same-cycle accept.
    if (redirect) begin
      pc_d  = redirect_addr;
      idx_d = '0;
      lat_d = '0;
      if (run) begin
        state_d = FETCH;
        ipc_d   = redirect_addr;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
    end
  end

  fetch_assembler #(
    .DATA_W      (DATA_W),
    .INSTR_BYTES (INSTR_BYTES),
    .IDX_W       (IW)
  ) u_asm (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect),
    .wr_en_i (cap),
    .last_i  (last),
    .idx_i   (idx_q),
    .data_i  (flash_rdata),
    .instr_o (instr)
  );

  assign flash_re    = (state_q == FETCH);
  assign flash_addr  = flash_re ? (pc_q + ADDR_W'(idx_q)) : '0;
  assign instr_pc    = ipc_q;
  assign instr_valid = (state_q == VALID);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-checking flash model
// and an in-order scoreboard of expected instruction words.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] word;
    logic [23:0] pc;
  } exp_t;

  logic        clk;
  logic        reset, run, redirect, instr_ready;
  logic [23:0] redirect_addr;
  logic        flash_re, instr_valid, busy;
  logic [23:0] flash_addr, instr_pc;
  logic [7:0]  flash_rdata;
  logic [31:0] instr;

  logic        reset_b, run_b, redirect_b, ready_b;
  logic [23:0] redirect_addr_b;
  logic        re_b, valid_b, busy_b;
  logic [23:0] addr_b, ipc_b;
  logic [7:0]  rdata_b;
  logic [31:0] instr_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  fetch_unit u_dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .flash_re      (flash_re),
    .flash_addr    (flash_addr),
    .flash_rdata   (flash_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .busy          (busy)
  );

  fetch_unit #(.RESET_PC(24'hFFFFFC)) u_dut_b (
    .clk           (clk),
    .reset         (reset_b),
    .run           (run_b),
    .redirect      (redirect_b),
    .redirect_addr (redirect_addr_b),
    .flash_re      (re_b),
    .flash_addr    (addr_b),
    .flash_rdata   (rdata_b),
    .instr         (instr_b),
    .instr_pc      (ipc_b),
    .instr_valid   (valid_b),
    .instr_ready   (ready_b),
    .busy          (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [31:0] w;
    case (a[23:2])
      22'h000000: w = 32'h00100283;
      22'h000001: w = 32'h00200303;
      22'h000002: w = 32'h006283b3;
      22'h000003: w = 32'h007001a3;
      22'h000004: w = 32'h11223344;
      22'h000005: w = 32'h55667788;
      22'h3FFFFF: w = 32'hAABBCCDD;
      default:    w = 32'h5A5A5A5A;
    endcase
    return w[a[1:0]*8 +: 8];
  endfunction

  // Data is only good in the third consecutive cycle on one address.
  logic [24:0] h1a = '0, h2a = '0, h1b = '0, h2b = '0;
  always @(posedge clk) begin
    h1a <= {flash_re, flash_addr};
    h2a <= h1a;
    h1b <= {re_b, addr_b};
    h2b <= h1b;
  end
  assign flash_rdata = (flash_re && h1a == {1'b1, flash_addr} &&
                        h2a == {1'b1, flash_addr}) ?
                       flash_byte(flash_addr) : 8'hEE;
  assign rdata_b = (re_b && h1b == {1'b1, addr_b} &&
                    h2b == {1'b1, addr_b}) ?
                   flash_byte(addr_b) : 8'hEE;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (instr_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_valid", 64'(instr_valid), 64'd1);
  endtask

  // Handshake will complete at the next rising edge.
  always @(negedge clk) begin
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 64'(instr), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", 64'(instr), 64'(e.word));
        chk("sb_pc", 64'(instr_pc), 64'(e.pc));
      end
    end
  end

  initial begin
    reset = 1'b1; run = 1'b0; redirect = 1'b0;
    redirect_addr = '0; instr_ready = 1'b0;
    reset_b = 1'b1; run_b = 1'b0; redirect_b = 1'b0;
    redirect_addr_b = '0; ready_b = 1'b0;
    repeat (2) tick();
    chk("rst_re", 64'(flash_re), 64'd0);
    chk("rst_addr", 64'(flash_addr), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_ipc", 64'(instr_pc), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    reset = 1'b0; run = 1'b1; instr_ready = 1'b1;
    sb.push_back('{32'h00100283, 24'h0});
    sb.push_back('{32'h00200303, 24'h4});
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("addr_seq", 64'(flash_addr), 64'(c / 3));
      chk("re_fetch", 64'(flash_re), 64'd1);
      chk("valid_early", 64'(instr_valid), 64'd0);
    end
    tick();
    chk("e12_valid", 64'(instr_valid), 64'd1);
    chk("e12_instr", 64'(instr), 64'h00100283);
    chk("e12_ipc", 64'(instr_pc), 64'd0);
    chk("e12_re", 64'(flash_re), 64'd0);
    tick();
    chk("e13_re", 64'(flash_re), 64'd1);
    chk("e13_addr", 64'(flash_addr), 64'd4);
    chk("e13_valid", 64'(instr_valid), 64'd0);
    repeat (11) tick();
    instr_ready = 1'b0;
    tick();
    chk("e25_valid", 64'(instr_valid), 64'd1);
    chk("e25_instr", 64'(instr), 64'h00200303);
    chk("e25_ipc", 64'(instr_pc), 64'd4);

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 64'(instr_valid), 64'd1);
      chk("hold_instr", 64'(instr), 64'h00200303);
      chk("hold_ipc", 64'(instr_pc), 64'd4);
      chk("hold_re", 64'(flash_re), 64'd0);
    end
    sb.push_back('{32'h006283b3, 24'h8});
    instr_ready = 1'b1;
    tick();
    chk("next_addr8", 64'(flash_addr), 64'd8);
    chk("next_re", 64'(flash_re), 64'd1);
    wait_valid(40);
    tick();

    redirect = 1'b1; redirect_addr = 24'h4;
    tick();
    redirect = 1'b0;
    chk("redir_addr4", 64'(flash_addr), 64'd4);
    chk("redir_valid", 64'(instr_valid), 64'd0);
    repeat (6) tick();
    chk("byte2_addr", 64'(flash_addr), 64'd6);
    redirect = 1'b1; redirect_addr = 24'hC;
    sb.push_back('{32'h007001a3, 24'hC});
    tick();
    redirect = 1'b0;
    chk("redir_addrC", 64'(flash_addr), 64'hC);
    chk("redir_reC", 64'(flash_re), 64'd1);
    wait_valid(40);
    chk("redir_ipc", 64'(instr_pc), 64'hC);
    tick();

    repeat (4) tick();
    run = 1'b0; instr_ready = 1'b0;
    sb.push_back('{32'h11223344, 24'h10});
    wait_valid(40);
    chk("rundrop_instr", 64'(instr), 64'h11223344);
    instr_ready = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_re", 64'(flash_re), 64'd0);
    chk("idle_valid", 64'(instr_valid), 64'd0);
    tick();
    chk("idle_busy2", 64'(busy), 64'd0);
    chk("idle_addr", 64'(flash_addr), 64'd0);

    run = 1'b1;
    repeat (8) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("arst_re", 64'(flash_re), 64'd0);
    chk("arst_addr", 64'(flash_addr), 64'd0);
    chk("arst_instr", 64'(instr), 64'd0);
    chk("arst_ipc", 64'(instr_pc), 64'd0);
    chk("arst_valid", 64'(instr_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    tick();
    reset = 1'b0;
    sb.push_back('{32'h00100283, 24'h0});
    tick();
    chk("restart_addr", 64'(flash_addr), 64'd0);
    chk("restart_re", 64'(flash_re), 64'd1);
    wait_valid(40);
    run = 1'b0;
    tick();
    chk("final_busy", 64'(busy), 64'd0);

    reset_b = 1'b0; run_b = 1'b1;
    tick();
    chk("b_addr0", 64'(addr_b), 64'hFFFFFC);
    for (int n = 0; n < 40 && valid_b !== 1'b1; n++) tick();
    chk("b_valid", 64'(valid_b), 64'd1);
    chk("b_instr", 64'(instr_b), 64'hAABBCCDD);
    chk("b_ipc", 64'(ipc_b), 64'hFFFFFC);
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
    chk("b_wrap_addr", 64'(addr_b), 64'h000000);
    chk("b_wrap_re", 64'(re_b), 64'd1);
    run_b = 1'b0;

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
